bcd_down_timer: RTL and testbench

Cascadable N-digit BCD down-counter with load handshake, start/pause/abort control, a programmable prescaler and optional auto-reload. It is the count-down counterpart of the team's decimal up-counters: a host loads a BCD preset, and the block decrements it to zero. On reaching zero it emits a one-cycle `done` pulse, and either stops or reloads. It sits between a control/host interface and display or event logic that consumes `count` and `done`.

---
 rtl/bcd_timer_pkg.sv | 29 ++
 rtl/bcd_down_digit.sv | 20 ++
 rtl/bcd_down_timer.sv | 142 ++++++++++++++
 tb/tb_bcd_down_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and BCD helpers for the BCD down-timer.
package bcd_timer_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 32;
  localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // True when a single digit holds a legal decimal value.
  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

  // True when the low 'digits' digits of v are all legal; v is zero-extended by the caller.
  function automatic logic all_bcd(input logic [MAX_W-1:0] v, input int unsigned digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && !is_bcd(v[i*BCD_W +: BCD_W])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the decrement chain: wraps 0 -> 9 and borrows upward.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  // Decrement only when a borrow arrives from below.
  always_comb begin
    borrow_out = borrow_in & (digit == 4'd0);
    digit_next = digit;
    if (borrow_in) begin
      digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// N-digit BCD down-counter with load handshake, run control, prescaler and auto-reload.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic                    load_ready,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    abort,
  input  logic                    auto_reload,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    busy,
  output logic                    done,
  output logic                    bad_load
);

  localparam int unsigned W          = BCD_W * DIGITS;
  localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    reload_q, reload_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            bad_load_q, bad_load_d;

  logic [W-1:0]    dec_c;
  logic [DIGITS:0] borrow_c;
  logic            count_zero_c, count_one_c;
  logic            load_acc_c, load_ok_c, start_go_c;
  logic            run_act_c, tick_c, term_c, reload_go_c;

  // Borrow chain: the tick feeds digit 0.
  assign borrow_c[0] = tick_c;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .digit      (count_q[g*BCD_W +: BCD_W]),
      .borrow_in  (borrow_c[g]),
      .digit_next (dec_c[g*BCD_W +: BCD_W]),
      .borrow_out (borrow_c[g+1])
    );
  end

  // Shared decode of the current cycle's events.
  assign count_zero_c = (count_q == '0);
  assign count_one_c  = (count_q == W'(1));
  assign load_acc_c   = load_valid & (state_q == ST_IDLE) & ~abort;
  assign load_ok_c    = all_bcd(MAX_W'(load_value), DIGITS);
  assign start_go_c   = (state_q == ST_IDLE) & ~abort & ~load_valid & ~pause & start;
  assign run_act_c    = (state_q == ST_RUN) & ~abort & ~pause;
  assign tick_c       = run_act_c & (presc_q == PRESC_LAST);
  // A borrow out of the top digit would mean underflow; treat it as terminal too.
  assign term_c       = tick_c & (count_one_c | borrow_c[DIGITS]);
  assign reload_go_c  = term_c & auto_reload & (reload_q != '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      presc_q    <= '0;
      done_q     <= 1'b0;
      bad_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      bad_load_q <= bad_load_d;
    end
  end

  // Next-state: abort beats pause beats start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_go_c && !count_zero_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                         state_d = ST_IDLE;
        else if (pause)                    state_d = ST_PAUSE;
        else if (term_c && !reload_go_c)   state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (abort)                         state_d = ST_IDLE;
        else if (start && !pause)          state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and pulse outputs.
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    bad_load_d = 1'b0;
    if (abort) begin
      presc_d = '0;
    end else if (load_acc_c) begin
      if (load_ok_c) begin
        count_d  = load_value;
        reload_d = load_value;
      end else begin
        bad_load_d = 1'b1;
      end
    end else if (start_go_c) begin
      if (count_zero_c) done_d  = 1'b1;
      else              presc_d = '0;
    end else if (run_act_c) begin
      if (tick_c) begin
        presc_d = '0;
        if (term_c) begin
          done_d  = 1'b1;
          count_d = reload_go_c ? reload_q : '0;
        end else begin
          count_d = dec_c;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign count      = count_q;
  assign done       = done_q;
  assign bad_load   = bad_load_q;
  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed testbench for bcd_down_timer: vector table plus multi-cycle sequences.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_value = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic        auto_reload = 1'b0;

  logic [15:0] count1, count3;
  logic        load_ready1, busy1, done1, bad1;
  logic        load_ready3, busy3, done3, bad3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready1), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .count(count1), .busy(busy1), .done(done1),
    .bad_load(bad1)
  );

  bcd_down_timer #(.DIGITS(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready3), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .count(count3), .busy(busy3), .done(done3),
    .bad_load(bad3)
  );

  typedef struct packed {
    logic        lv;
    logic [15:0] val;
    logic        st;
    logic        pa;
    logic        ab;
    logic [15:0] e_cnt;
    logic        e_done;
    logic        e_bad;
    logic        e_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  function automatic vec_t mkv(input logic lv, input logic [15:0] val, input logic st,
                               input logic pa, input logic ab, input logic [15:0] ec,
                               input logic ed, input logic eb, input logic ey);
    vec_t v;
    v.lv = lv; v.val = val; v.st = st; v.pa = pa; v.ab = ab;
    v.e_cnt = ec; v.e_done = ed; v.e_bad = eb; v.e_busy = ey;
    return v;
  endfunction

  // Returns at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    load_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // lv val st pa ab | count done bad busy
    vecs[0]  = mkv(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
    vecs[1]  = mkv(0, 16'h0000, 1, 0, 0, 16'h1000, 0, 0, 1);
    vecs[2]  = mkv(0, 16'h0000, 0, 0, 0, 16'h0999, 0, 0, 1);
    vecs[3]  = mkv(0, 16'h0000, 0, 0, 1, 16'h0999, 0, 0, 0);
    vecs[4]  = mkv(1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0);
    vecs[5]  = mkv(0, 16'h0000, 1, 0, 0, 16'h0100, 0, 0, 1);
    vecs[6]  = mkv(0, 16'h0000, 0, 0, 0, 16'h0099, 0, 0, 1);
    vecs[7]  = mkv(0, 16'h0000, 1, 1, 1, 16'h0099, 0, 0, 0);
    vecs[8]  = mkv(1, 16'h00A5, 0, 0, 0, 16'h0099, 0, 1, 0);
    vecs[9]  = mkv(0, 16'h0000, 0, 0, 0, 16'h0099, 0, 0, 0);
    vecs[10] = mkv(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
    vecs[11] = mkv(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0);
    vecs[12] = mkv(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
    vecs[13] = mkv(1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0, 0);
    vecs[14] = mkv(0, 16'h0000, 1, 0, 0, 16'h0001, 0, 0, 1);
    vecs[15] = mkv(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0);
    vecs[16] = mkv(1, 16'h0003, 1, 0, 0, 16'h0003, 0, 0, 0);

    // Reset values, observed before any clock edge.
    #2;
    chk("rst_count", 32'(count1), 32'h0);
    chk("rst_load_ready", 32'(load_ready1), 32'h1);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_done", 32'(done1), 32'h0);
    chk("rst_bad", 32'(bad1), 32'h0);
    do_reset();

    // Table: loads, borrow chain, abort, priority, bad load, zero start.
    for (int i = 0; i < 17; i++) begin
      load_valid = vecs[i].lv; load_value = vecs[i].val;
      start = vecs[i].st; pause = vecs[i].pa; abort = vecs[i].ab;
      edge1();
      chk($sformatf("vec%0d_count", i), 32'(count1), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_done", i), 32'(done1), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_bad", i), 32'(bad1), 32'(vecs[i].e_bad));
      chk($sformatf("vec%0d_busy", i), 32'(busy1), 32'(vecs[i].e_busy));
    end
    load_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;

    // Load 0012 and run to zero at one decrement per cycle.
    load_valid = 1'b1; load_value = 16'h0012;
    edge1();
    chk("run12_load", 32'(count1), 32'h0012);
    load_valid = 1'b0; start = 1'b1;
    edge1();
    chk("run12_busy", 32'(busy1), 32'h1);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      edge1();
      chk($sformatf("run12_count%0d", i), 32'(count1), 32'(to_bcd(12 - i)));
      chk($sformatf("run12_done%0d", i), 32'(done1), 32'(i == 12));
    end
    edge1();
    chk("run12_idle", 32'(busy1), 32'h0);
    chk("run12_done_once", 32'(done1), 32'h0);

    // Auto-reload of 0003, then release auto_reload and stop at zero.
    load_valid = 1'b1; load_value = 16'h0003;
    edge1();
    load_valid = 1'b0; start = 1'b1; auto_reload = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int exp_c;
      exp_c = (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3;
      edge1();
      chk($sformatf("ar_count%0d", i), 32'(count1), 32'(to_bcd(exp_c)));
      chk($sformatf("ar_done%0d", i), 32'(done1), 32'(i % 3 == 2));
      chk($sformatf("ar_busy%0d", i), 32'(busy1), 32'h1);
    end
    auto_reload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk($sformatf("ar_stop_count%0d", i), 32'(count1), 32'(to_bcd(2 - i)));
      chk($sformatf("ar_stop_done%0d", i), 32'(done1), 32'(i == 2));
    end
    chk("ar_stop_idle", 32'(busy1), 32'h0);

    // PRESCALE=3, preset 2, prescaler frozen for 5 edges: done 6+5 edges after start.
    do_reset();
    load_valid = 1'b1; load_value = 16'h0002;
    edge1();
    load_valid = 1'b0; start = 1'b1;
    edge1();
    chk("ps_busy", 32'(busy3), 32'h1);
    for (int e = 1; e <= 12; e++) begin
      int exp_c;
      pause = (e >= 2 && e <= 5);
      start = (e <= 6);
      exp_c = (e <= 7) ? 2 : (e <= 10) ? 1 : 0;
      edge1();
      chk($sformatf("ps_count%0d", e), 32'(count3), 32'(to_bcd(exp_c)));
      chk($sformatf("ps_done%0d", e), 32'(done3), 32'(e == 11));
    end
    chk("ps_idle", 32'(busy3), 32'h0);
    start = 1'b0; pause = 1'b0;

    // Asynchronous reset in the middle of a run.
    do_reset();
    load_valid = 1'b1; load_value = 16'h0005;
    edge1();
    load_valid = 1'b0; start = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    edge1();
    chk("arst_pre_count", 32'(count1), 32'h0003);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count1), 32'h0);
    chk("arst_busy", 32'(busy1), 32'h0);
    chk("arst_load_ready", 32'(load_ready1), 32'h1);
    #1 rst = 1'b0;
    edge1();
    chk("arst_after_count", 32'(count1), 32'h0);
    chk("arst_after_busy", 32'(busy1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
